// File: rtl/instream_bank.sv
// instream_bank: bank of NCH input-stream players feeding the input row of the node grid.
//
// Each channel plays up to DEPTH preloaded signed words, in order, on a write/wready port.
// The number of words played is min(length[c], DEPTH). Each channel raises a sticky done flag
// after its last word. A one-cycle restart pulse replays every channel from index 0.
//
// Optional feature macro: INSTREAM_LOOP_EN
//   When defined, the loop port exists. On its final transfer, a channel with loop[c]=1 wraps
//   to index 0 without a bubble and does not assert done.
//
// Ports:
//   clk      in   rising-edge clock
//   rst      in   synchronous active-low reset
//   length   in   per-channel word count (LW bits each), clamped to DEPTH
//   data     in   preloaded words; channel c owns data[c*DEPTH +: DEPTH]
//   restart  in   one-cycle pulse that restarts all channels
//   wready   in   per-channel downstream accept
//   loop     in   per-channel looping enable (INSTREAM_LOOP_EN only)
//   write    out  per-channel word offered (registered)
//   out      out  per-channel offered word (registered)
//   done     out  per-channel completion flag (registered)
//   all_done out  AND of all done bits (registered)
module instream_bank #(
    parameter int unsigned NCH   = 4,
    parameter int unsigned DEPTH = 64,
    parameter int unsigned W     = 11,
    parameter int unsigned LW    = $clog2(DEPTH + 1)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [LW-1:0]       length  [0:NCH-1],
    input  logic signed [W-1:0] data    [0:NCH*DEPTH-1],
    input  logic                restart,
    input  logic [NCH-1:0]      wready,
`ifdef INSTREAM_LOOP_EN
    input  logic [NCH-1:0]      loop,
`endif
    output logic [NCH-1:0]      write,
    output logic signed [W-1:0] out     [0:NCH-1],
    output logic [NCH-1:0]      done,
    output logic                all_done
);

    localparam int unsigned IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned AW = (NCH * DEPTH > 1) ? $clog2(NCH * DEPTH) : 1;

    typedef enum logic [1:0] {
        StStart,
        StRun,
        StDone
    } state_e;

    state_e              state_q [NCH];
    state_e              state_d [NCH];
    logic [IW-1:0]       idx_q   [NCH];
    logic [IW-1:0]       idx_d   [NCH];
    logic [LW-1:0]       eff     [NCH];
    logic [AW-1:0]       rd_addr [NCH];
    logic signed [W-1:0] out_d   [NCH];
    logic [NCH-1:0]      write_d;
    logic [NCH-1:0]      done_d;
    logic [NCH-1:0]      load;
    logic [NCH-1:0]      loop_en;

`ifdef INSTREAM_LOOP_EN
    assign loop_en = loop;
`else
    assign loop_en = '0;
`endif

    always_comb begin
        for (int c = 0; c < NCH; c++) begin
            state_d[c] = state_q[c];
            idx_d[c]   = idx_q[c];
            write_d[c] = write[c];
            done_d[c]  = done[c];
            load[c]    = 1'b0;
            eff[c]     = (length[c] > LW'(DEPTH)) ? LW'(DEPTH) : length[c];

            if (restart) begin
                state_d[c] = StStart;
                idx_d[c]   = '0;
                write_d[c] = 1'b0;
                done_d[c]  = 1'b0;
            end else begin
                unique case (state_q[c])
                    StStart: begin
                        idx_d[c] = '0;
                        if (eff[c] == '0) begin
                            state_d[c] = StDone;
                            done_d[c]  = 1'b1;
                            write_d[c] = 1'b0;
                        end else begin
                            state_d[c] = StRun;
                            write_d[c] = 1'b1;
                            load[c]    = 1'b1;
                        end
                    end
                    StRun: begin
                        if (write[c] && wready[c]) begin
                            // idx+1 never exceeds DEPTH, so it fits in LW bits.
                            if (LW'(idx_q[c]) + LW'(1) < eff[c]) begin
                                idx_d[c] = idx_q[c] + IW'(1);
                                load[c]  = 1'b1;
                            end else if (loop_en[c]) begin
                                idx_d[c] = '0;
                                load[c]  = 1'b1;
                            end else begin
                                state_d[c] = StDone;
                                write_d[c] = 1'b0;
                                done_d[c]  = 1'b1;
                            end
                        end
                    end
                    StDone: begin
                        write_d[c] = 1'b0;
                    end
                    default: begin
                        state_d[c] = StStart;
                        write_d[c] = 1'b0;
                    end
                endcase
            end

            // idx_d is always below DEPTH, so the read stays inside this channel's slice.
            rd_addr[c] = AW'(c * DEPTH) + AW'(idx_d[c]);
            out_d[c]   = load[c] ? data[rd_addr[c]] : out[c];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int c = 0; c < NCH; c++) begin
                state_q[c] <= StStart;
                idx_q[c]   <= '0;
                out[c]     <= '0;
            end
            write    <= '0;
            done     <= '0;
            all_done <= 1'b0;
        end else begin
            for (int c = 0; c < NCH; c++) begin
                state_q[c] <= state_d[c];
                idx_q[c]   <= idx_d[c];
                out[c]     <= out_d[c];
            end
            write    <= write_d;
            done     <= done_d;
            // Taken from the next-state vector so it rises with the last done bit.
            all_done <= &done_d;
        end
    end

endmodule

// File: tb/tb_instream_bank.sv
// Self-checking bench for instream_bank: random data and wready checked every cycle against a
// counter-based reference model, plus directed transfer-count checks.
module tb_instream_bank;

    localparam int NCH   = 4;
    localparam int DEPTH = 64;
    localparam int W     = 11;
    localparam int LW    = $clog2(DEPTH + 1);
    localparam int AW    = $clog2(NCH * DEPTH);

    logic                clk = 1'b0;
    logic                rst = 1'b0;
    logic                restart = 1'b0;
    logic [LW-1:0]       length [0:NCH-1];
    logic signed [W-1:0] data   [0:NCH*DEPTH-1];
    logic [NCH-1:0]      wready = '1;
    logic [NCH-1:0]      loop = '0;
    logic [NCH-1:0]      write;
    logic signed [W-1:0] out    [0:NCH-1];
    logic [NCH-1:0]      done;
    logic                all_done;

    // Reference model: a channel is either waiting for its start edge or playing; n counts
    // words consumed since the start, and the offered word is data[base + n mod eff].
    bit                  m_alive [NCH];
    int                  m_n     [NCH];
    logic                m_write [NCH];
    logic signed [W-1:0] m_out   [NCH];
    logic                m_done  [NCH];
    int                  dxf     [NCH];

    int checks = 0;
    int errors = 0;

    instream_bank #(
        .NCH  (NCH),
        .DEPTH(DEPTH),
        .W    (W),
        .LW   (LW)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .length  (length),
        .data    (data),
        .restart (restart),
        .wready  (wready),
`ifdef INSTREAM_LOOP_EN
        .loop    (loop),
`endif
        .write   (write),
        .out     (out),
        .done    (done),
        .all_done(all_done)
    );

    always #5 clk = ~clk;

    function automatic int eff_of(input int c);
        int l;
        l = int'(length[c]);
        return (l > DEPTH) ? DEPTH : l;
    endfunction

    function automatic logic signed [W-1:0] word(input int c, input int i);
        return data[AW'(c * DEPTH + i)];
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_edge();
        for (int c = 0; c < NCH; c++) begin
            int e;
            e = eff_of(c);
            if (!rst) begin
                m_alive[c] = 0; m_n[c] = 0;
                m_write[c] = 1'b0; m_out[c] = '0; m_done[c] = 1'b0;
            end else if (restart) begin
                m_alive[c] = 0; m_n[c] = 0;
                m_write[c] = 1'b0; m_done[c] = 1'b0;
            end else if (!m_alive[c]) begin
                m_alive[c] = 1; m_n[c] = 0;
                if (e == 0) begin
                    m_done[c] = 1'b1; m_write[c] = 1'b0;
                end else begin
                    m_write[c] = 1'b1; m_out[c] = word(c, 0);
                end
            end else if (m_write[c] && wready[c]) begin
                m_n[c]++;
                if ((m_n[c] % e) == 0 && !loop[c]) begin
                    m_write[c] = 1'b0; m_done[c] = 1'b1;
                end else begin
                    m_out[c] = word(c, m_n[c] % e);
                end
            end
        end
    endtask

    task automatic tick();
        logic exp_all;
        for (int c = 0; c < NCH; c++)
            if (rst && write[c] && wready[c]) dxf[c]++;
        @(posedge clk);
        model_edge();
        #1;
        exp_all = 1'b1;
        for (int c = 0; c < NCH; c++) begin
            chk($sformatf("write[%0d]", c), 32'(write[c]), 32'(m_write[c]));
            chk($sformatf("out[%0d]", c), 32'(out[c]), 32'(m_out[c]));
            chk($sformatf("done[%0d]", c), 32'(done[c]), 32'(m_done[c]));
            exp_all = exp_all & m_done[c];
        end
        chk("all_done", 32'(all_done), 32'(exp_all));
    endtask

    task automatic clear_counts();
        for (int c = 0; c < NCH; c++) dxf[c] = 0;
    endtask

    task automatic pulse_restart();
        restart = 1'b1;
        tick();
        restart = 1'b0;
        clear_counts();
    endtask

    initial begin
        int got;
        for (int i = 0; i < NCH * DEPTH; i++) data[i] = W'($urandom);
        length[0] = LW'(3); length[1] = LW'(0); length[2] = LW'(64); length[3] = LW'(5);
        for (int c = 0; c < NCH; c++) begin
            m_alive[c] = 0; m_n[c] = 0; m_write[c] = 1'b0; m_out[c] = '0; m_done[c] = 1'b0;
        end
        clear_counts();

        // Reset, then the basic mixed-length run with wready all high.
        restart = 1'b1;  // ignored while in reset
        repeat (3) tick();
        restart = 1'b0;
        rst = 1'b1;
        clear_counts();
        repeat (70) tick();
        chk("basic_xfers0", 32'(dxf[0]), 32'd3);
        chk("basic_xfers1", 32'(dxf[1]), 32'd0);
        chk("basic_xfers2", 32'(dxf[2]), 32'd64);
        chk("basic_xfers3", 32'(dxf[3]), 32'd5);
        chk("basic_all_done", 32'(all_done), 32'd1);

        // Stall pattern on channel 0, length 4.
        length[0] = LW'(4);
        pulse_restart();
        tick();
        begin
            logic [6:0] pat;
            pat = 7'b1011001;  // applied LSB first: 1,0,0,1,1,0,1
            for (int i = 0; i < 7; i++) begin
                wready[0] = pat[i];
                tick();
            end
        end
        chk("stall_xfers0", 32'(dxf[0]), 32'd4);
        chk("stall_done0", 32'(done[0]), 32'd1);
        wready = '1;

        // Length above DEPTH is clamped.
        length[2] = LW'(70);
        pulse_restart();
        repeat (75) tick();
        chk("clamp_xfers2", 32'(dxf[2]), 32'd64);

        // Restart after two of five words on channel 3.
        pulse_restart();
        got = 0;
        for (int i = 0; i < 20 && got == 0; i++) begin
            tick();
            if (dxf[3] == 2) got = 1;
        end
        chk("mid_wait", 32'(got), 32'd1);
        pulse_restart();
        chk("mid_done_cleared", 32'(done[3]), 32'd0);
        repeat (8) tick();
        chk("mid_xfers3", 32'(dxf[3]), 32'd5);
        chk("mid_done3", 32'(done[3]), 32'd1);

        // One-cycle reset mid-stream.
        pulse_restart();
        repeat (3) tick();
        rst = 1'b0;
        tick();
        chk("rst_write", 32'(write), 32'd0);
        rst = 1'b1;
        clear_counts();
        repeat (70) tick();
        chk("rst_xfers0", 32'(dxf[0]), 32'd4);
        chk("rst_xfers2", 32'(dxf[2]), 32'd64);

`ifdef INSTREAM_LOOP_EN
        // Looping playback on channel 0, length 3.
        length[0] = LW'(3);
        loop[0] = 1'b1;
        pulse_restart();
        repeat (6) tick();  // start edge, then d0 d1 d2 d0 d1
        loop[0] = 1'b0;
        repeat (4) tick();
        chk("loop_xfers0", 32'(dxf[0]), 32'd6);
        chk("loop_done0", 32'(done[0]), 32'd1);
`endif

        // Randomised phase: random wready, occasional restarts with new lengths.
        for (int i = 0; i < 400; i++) begin
            wready = NCH'($urandom);
            if ($urandom_range(0, 29) == 0) begin
                for (int c = 0; c < NCH; c++) length[c] = LW'($urandom_range(0, 70));
`ifdef INSTREAM_LOOP_EN
                loop = NCH'($urandom);
`endif
                restart = 1'b1;
            end else begin
                restart = 1'b0;
            end
            if ($urandom_range(0, 199) == 0) rst = 1'b0;
            else rst = 1'b1;
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
